// File: rtl/div8_seq.sv
// Iterative unsigned restoring divider (one shift + trial subtract per clock)
// with a start/busy/done handshake for the ALU controller.
module div8_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             ZF,
   output logic             DZ
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   p;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   p_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic [WIDTH:0]   p_nxt;
   logic [WIDTH-1:0] q_nxt;

   // One restoring step; the extra MSB of diff is the borrow out of P - B.
   always_comb begin
      p_sh   = {p[WIDTH-1:0], dvd[WIDTH-1]};
      diff   = {1'b0, p_sh} - {2'b00, dvs};
      borrow = diff[WIDTH+1];
      p_nxt  = borrow ? p_sh : diff[WIDTH:0];
      q_nxt  = {quo[WIDTH-2:0], ~borrow};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         Q     <= '0;
         R     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ZF    <= 1'b0;
         DZ    <= 1'b0;
         cnt   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         quo   <= '0;
         p     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (B != '0) begin
                     dvd   <= A;
                     dvs   <= B;
                     p     <= '0;
                     quo   <= '0;
                     cnt   <= '0;
                     state <= CALC;
                  end else begin
                     Q     <= '1;
                     R     <= A;
                     DZ    <= 1'b1;
                     ZF    <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            CALC: begin
               p   <= p_nxt;
               quo <= q_nxt;
               dvd <= {dvd[WIDTH-2:0], 1'b0};
               cnt <= cnt + CW'(1);
               // Results are published only on the final step so Q/R stay stable mid-division.
               if (cnt == LAST) begin
                  Q     <= q_nxt;
                  R     <= p_nxt[WIDTH-1:0];
                  ZF    <= (q_nxt == '0);
                  DZ    <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
